tick_gen: RTL
=============

// Module: tick_gen
// PURPOSE
//  Multi-channel programmable tick generator: one shared ms prescaler on i_clk
//  feeds N_CH independent interval counters, each emitting 1-cycle strobes.
//  Successor to the fixed single-interval strobe: exact periods, runtime-writable
//  intervals, per-channel enable and phase restart. Drives stopwatch/display/debounce timing.
// PARAMETERS
//  CLOCK_KHZ     24000  i_clk cycles per ms (prescaler period); must be >=2
//  N_CH          4      number of tick channels, 1..16
//  IVL_W         16     interval register width (ms units)
//  DEFAULT_IVL   10     reset interval of every channel (ms), < 2**IVL_W
// PORTS
//  i_clk          in   1              single clock, all logic on posedge
//  i_rst          in   1              synchronous, active-high reset
//  i_enable       in   1              global run; low freezes prescaler and all channels
//  i_ch_en        in   N_CH           per-channel enable
//  i_wr           in   1              interval write strobe
//  i_wr_ch        in   $clog2(N_CH)+1 channel index for write
//  i_wr_ivl       in   IVL_W          interval value (ms); 0 = channel silent
//  i_ch_oneshot   in   N_CH           per-channel one-shot select (see CONFIGURATION)
//  o_base_tick    out  1              1-cycle strobe every CLOCK_KHZ cycles (1 ms)
//  o_tick         out  N_CH           per-channel 1-cycle strobes
//  o_done         out  N_CH           one-shot expired flags
// BEHAVIOUR
//  - Reset: prescaler=0, channel counters=0, intervals=DEFAULT_IVL, all outputs 0.
//  - Prescaler: while i_enable, counts 0..CLOCK_KHZ-1 then wraps; wrap cycle = "ms".
//    o_base_tick registered: high exactly the cycle after each wrap edge, period exactly
//    CLOCK_KHZ cycles (no +1/+2 slop). i_enable low: prescaler holds, o_base_tick 0.
//  - Channel c (on ms, i_ch_en[c]=1, ivl[c]!=0): if cnt==ivl-1 -> cnt<=0, o_tick[c]<=1,
//    else cnt<=cnt+1. o_tick[c] asserts in the same cycle as the o_base_tick it completes.
//    Period = ivl*CLOCK_KHZ cycles. ivl=1 -> o_tick[c] mirrors o_base_tick.
//  - i_ch_en[c]=0: cnt<=0, o_tick[c]=0. Re-enable: first tick after full ivl ms.
//  - Write (i_wr, i_wr_ch<N_CH): ivl[ch]<=i_wr_ivl, cnt[ch]<=0 (phase restart), o_done
//    cleared. Write wins over simultaneous wrap on that channel: tick suppressed.
//    i_wr_ch>=N_CH: write ignored, no state change. Other channels unaffected.
//  - ivl=0: cnt held 0, never ticks.
//  - i_rst mid-count: everything returns to reset values next edge; i_rst dominates i_wr.
//  - Counters IVL_W bits; cnt never exceeds ivl-1, no overflow possible.
// CONFIGURATION
//  Macro TICK_GEN_ONESHOT_EN:
//   defined   - channel with i_ch_oneshot[c]=1 ticks once, sets o_done[c]=1, then stops
//               (cnt held 0) until a write to c or i_ch_en[c] low; either clears o_done[c].
//               i_ch_oneshot sampled at each tick; changing it mid-count takes effect on
//               the next expiry.
//   undefined - i_ch_oneshot ignored, all channels periodic, o_done tied 0.
// STRUCTURE
//  - tick_gen_defs.vh: prescaler width function/localparam ($clog2(CLOCK_KHZ)),
//    channel-index width, DEFAULT_IVL range check macro.
//  - Sub-module tick_gen_ch: one interval register + counter + tick/done regs,
//    instantiated N_CH times via generate; top holds prescaler and write decode.
// TESTING (sim with CLOCK_KHZ=4, N_CH=4, DEFAULT_IVL=10)
//  1. Reset, i_enable=1 -> o_base_tick high at cycles 4,8,12,... after enable; period 4.
//  2. Write ch0 ivl=3, ch_en=1 -> o_tick[0] every 12 cycles, coincident with every
//     3rd o_base_tick; ch1 (ivl 10) ticks every 40 cycles.
//  3. ch2 ivl=0 -> no o_tick[2] over 200 cycles; then write 2 mid-stream -> first
//     tick exactly 2 base ticks later.
//  4. Write ch0 ivl=3 in the wrap cycle of its 3rd ms -> no tick, next tick 3 ms later;
//     write with i_wr_ch=7 -> no channel changes.
//  5. Drop i_enable for 5 cycles mid-count -> phase shifts by exactly 5 cycles;
//     i_rst mid-count -> outputs 0, intervals back to 10.
//  6. TICK_GEN_ONESHOT_EN, ch3 oneshot ivl=2 -> single tick at 8 cycles, o_done[3]=1,
//     no further ticks; write ch3 -> o_done clears, tick again after 2 ms.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// Shared sizing helpers for the tick generator: prescaler width and write-index width.
package tick_gen_pkg;

  localparam int unsigned MIN_CLOCK_KHZ = 32'd2;

  function automatic int unsigned pre_width(input int unsigned clock_khz);
    int unsigned w;
    w = $clog2(clock_khz);
    if (clock_khz < MIN_CLOCK_KHZ) begin
      w = 32'd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  function automatic int unsigned ch_idx_width(input int unsigned n_ch);
    int unsigned w;
    w = $clog2(n_ch);
    return w + 32'd1;
  endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// One tick channel: interval register, ms counter, registered tick strobe and done flag.
// TICK_GEN_ONESHOT_EN enables one-shot channels; otherwise every channel is periodic.
module tick_gen_ch
  import tick_gen_pkg::*;
#(
  parameter int unsigned IVL_W       = 16,
  parameter int unsigned DEFAULT_IVL = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ms,
  input  logic             i_ch_en,
  input  logic             i_wr,
  input  logic [IVL_W-1:0] i_wr_ivl,
  input  logic             i_oneshot,
  output logic             o_tick,
  output logic             o_done
);

  localparam logic [IVL_W-1:0] RST_IVL = IVL_W'(DEFAULT_IVL);
  localparam logic [IVL_W-1:0] IVL_ONE = IVL_W'(1);

  logic [IVL_W-1:0] ivl_q, ivl_d;
  logic [IVL_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             oneshot_s;
  logic             run_s;

`ifdef TICK_GEN_ONESHOT_EN
  assign oneshot_s = i_oneshot;
  assign run_s     = ~done_q;
`else
  logic unused_oneshot_s;
  assign unused_oneshot_s = i_oneshot;
  assign oneshot_s        = 1'b0;
  assign run_s            = 1'b1;
`endif

  // Write beats disable beats expiry, so a write landing on a wrap swallows that tick.
  always_comb begin
    ivl_d  = ivl_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    done_d = done_q;
    if (i_wr) begin
      ivl_d  = i_wr_ivl;
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (!i_ch_en) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (i_ms && run_s && (ivl_q != '0)) begin
      if (cnt_q == (ivl_q - IVL_ONE)) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        done_d = oneshot_s;
      end else begin
        cnt_d  = cnt_q + IVL_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ivl_q  <= RST_IVL;
      cnt_q  <= '0;
      tick_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      ivl_q  <= ivl_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      done_q <= done_d;
    end
  end

  assign o_tick = tick_q;
  assign o_done = done_q;

endmodule

// File: rtl/tick_gen.sv
// Multi-channel tick generator: shared 1 ms prescaler, write decode, N_CH interval channels.
// Define TICK_GEN_ONESHOT_EN to enable per-channel one-shot mode (o_done); otherwise o_done is 0.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int unsigned CLOCK_KHZ   = 24000,
  parameter int unsigned N_CH        = 4,
  parameter int unsigned IVL_W       = 16,
  parameter int unsigned DEFAULT_IVL = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic [N_CH-1:0]       i_ch_en,
  input  logic                  i_wr,
  input  logic [$clog2(N_CH):0] i_wr_ch,
  input  logic [IVL_W-1:0]      i_wr_ivl,
  input  logic [N_CH-1:0]       i_ch_oneshot,
  output logic                  o_base_tick,
  output logic [N_CH-1:0]       o_tick,
  output logic [N_CH-1:0]       o_done
);

  localparam int unsigned      PRE_W    = pre_width(CLOCK_KHZ);
  localparam int unsigned      CH_W     = ch_idx_width(N_CH);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLOCK_KHZ - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             base_tick_q, base_tick_d;
  logic             ms_s;
  logic [N_CH-1:0]  wr_sel_s;
  logic [N_CH-1:0]  tick_s;
  logic [N_CH-1:0]  done_s;

  // The wrap cycle is the ms event; channels see it combinationally so their
  // registered ticks line up with the registered base tick.
  always_comb begin
    pre_d = pre_q;
    ms_s  = 1'b0;
    if (i_enable) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        ms_s  = 1'b1;
      end else begin
        pre_d = pre_q + PRE_ONE;
      end
    end else begin
      pre_d = pre_q;
    end
    base_tick_d = ms_s;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pre_q       <= '0;
      base_tick_q <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      base_tick_q <= base_tick_d;
    end
  end

  // Full-width compare, so out-of-range indices select nothing.
  always_comb begin
    wr_sel_s = '0;
    for (int c = 0; c < int'(N_CH); c++) begin
      wr_sel_s[c] = i_wr && (i_wr_ch == CH_W'(c));
    end
  end

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    tick_gen_ch #(
      .IVL_W      (IVL_W),
      .DEFAULT_IVL(DEFAULT_IVL)
    ) u_ch (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_ms     (ms_s),
      .i_ch_en  (i_ch_en[g]),
      .i_wr     (wr_sel_s[g]),
      .i_wr_ivl (i_wr_ivl),
      .i_oneshot(i_ch_oneshot[g]),
      .o_tick   (tick_s[g]),
      .o_done   (done_s[g])
    );
  end

  assign o_base_tick = base_tick_q;
  assign o_tick      = tick_s;
  assign o_done      = done_s;

endmodule
